// File: rtl/melody_sequencer.sv
// Melody ROM sequencer: walks packed note words and hands the tone generator a
// half-period and enable, timing beats, articulation gaps, rests, loop and stop.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [17:0]       half_period,
    output logic              tone_en,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOAD, DECODE, PLAY, GAP} state_t;

    localparam int CNT_W = $clog2(15 * BEAT_CYCLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    state_t            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [17:0]       hp_q, hp_d;
    logic              tone_q, tone_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              at_end;

    logic [3:0] dur;
    logic [3:0] note;
    logic [1:0] oct;
    logic       unused_bits;

    assign dur         = rom_data[11:8];
    assign note        = rom_data[7:4];
    assign oct         = rom_data[3:2];
    assign unused_bits = ^rom_data[1:0];

    // Octave-4 half-periods at 100 MHz; higher octaves are right shifts of these.
    function automatic logic [17:0] base_period(input logic [3:0] n);
        case (n)
            4'd1:    return 18'd191113;
            4'd2:    return 18'd180388;
            4'd3:    return 18'd170262;
            4'd4:    return 18'd160706;
            4'd5:    return 18'd151685;
            4'd6:    return 18'd143173;
            4'd7:    return 18'd135137;
            4'd8:    return 18'd127553;
            4'd9:    return 18'd120394;
            4'd10:   return 18'd113636;
            4'd11:   return 18'd107258;
            4'd12:   return 18'd101238;
            default: return 18'd0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        hp_d     = hp_q;
        tone_d   = tone_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        at_end   = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                tone_d = 1'b0;
                if (play) state_d = LOAD;
            end
            LOAD: state_d = DECODE;
            DECODE: begin
                if (dur == 4'd0) begin
                    at_end = 1'b1;
                end else begin
                    if (note >= 4'd1 && note <= 4'd12) begin
                        hp_d   = base_period(note) >> oct;
                        tone_d = 1'b1;
                    end else begin
                        tone_d = 1'b0;
                    end
                    strobe_d = 1'b1;
                    cnt_d    = cnt_t'(dur) * cnt_t'(BEAT_CYCLES) - cnt_t'(GAP_CYCLES) - cnt_t'(1);
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (cnt_q == '0) begin
                    tone_d  = 1'b0;
                    cnt_d   = cnt_t'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (addr_q == '1) begin
                        at_end = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The last ROM word and the address wrap share one end-of-song path.
        if (at_end) begin
            addr_d = '0;
            if (loop_en) begin
                state_d = LOAD;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (!play) begin
            state_d  = IDLE;
            tone_d   = 1'b0;
            addr_d   = '0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            hp_q     <= '0;
            tone_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            hp_q     <= hp_d;
            tone_q   <= tone_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr    = addr_q;
    assign half_period = hp_q;
    assign tone_en     = tone_q;
    assign note_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: table of single-note songs, a timeline model of
// whole songs for random ROMs, and hand-built stop/reset/loop/wrap sequences.
module tb_melody_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          play;
    logic          loop_en;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [17:0]   half_period;
    logic          tone_en;
    logic          note_strobe;
    logic          busy;
    logic          done;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .loop_en    (loop_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .half_period(half_period),
        .tone_en    (tone_en),
        .note_strobe(note_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [8];
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [2:0]  addr;
        logic [17:0] hp;
        logic        tone;
        logic        strobe;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        logic [11:0] word;
        logic [17:0] exp_hp;
        logic        exp_tone;
        int          exp_high;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    obs_t        exp_q[$];
    logic [17:0] model_hp;
    logic [17:0] ref_tab [12] = '{18'd191113, 18'd180388, 18'd170262, 18'd160706,
                                  18'd151685, 18'd143173, 18'd135137, 18'd127553,
                                  18'd120394, 18'd113636, 18'd107258, 18'd101238};
    vec_t        vecs [8];

    function automatic logic [11:0] w(input int d, input int n, input int o);
        return {d[3:0], n[3:0], o[1:0], 2'b00};
    endfunction

    function automatic obs_t mk(input int a, input logic [17:0] h, input logic t,
                                input logic s, input logic b, input logic dn);
        return {a[2:0], h, t, s, b, dn};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        play = 1'b0;
        loop_en = 1'b0;
        tick();
        rst = 1'b0;
        model_hp = 18'd0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 8; i++) rom[i] = 12'h000;
    endtask

    // Song timeline: every word costs a LOAD and DECODE cycle, a played word then
    // lasts dur beats (tone for all but the gap), and the end either loops or
    // spends one idle cycle with done before play restarts it.
    task automatic buildTrace(input int ncyc, input logic lp);
        int   i, d, n, o;
        logic pitched;
        i = 0;
        exp_q.delete();
        while (exp_q.size() < ncyc) begin
            d = int'(rom[i][11:8]);
            n = int'(rom[i][7:4]);
            o = int'(rom[i][3:2]);
            exp_q.push_back(mk(i, model_hp, 1'b0, 1'b0, 1'b1, 1'b0));
            exp_q.push_back(mk(i, model_hp, 1'b0, 1'b0, 1'b1, 1'b0));
            if (d != 0) begin
                pitched = (n >= 1 && n <= 12);
                if (pitched) model_hp = ref_tab[n-1] >> o;
                for (int c = 0; c < d * BEAT; c++)
                    exp_q.push_back(mk(i, model_hp, pitched && (c < d * BEAT - GAP),
                                       c == 0, 1'b1, 1'b0));
            end
            if (d == 0 || i == 7) begin
                if (!lp) exp_q.push_back(mk(0, model_hp, 1'b0, 1'b0, 1'b0, 1'b1));
                i = 0;
            end else begin
                i++;
            end
        end
    endtask

    task automatic runTrace(input string name, input int ncyc, input logic lp);
        obs_t got;
        obs_t exp;
        loop_en = lp;
        buildTrace(ncyc, lp);
        play = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            got = {rom_addr, half_period, tone_en, note_strobe, busy, done};
            exp = exp_q[k];
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL %s cycle %0d: got addr=%0d hp=%0d tone=%b strobe=%b busy=%b done=%b, expected addr=%0d hp=%0d tone=%b strobe=%b busy=%b done=%b",
                         name, k, got.addr, got.hp, got.tone, got.strobe, got.busy, got.done,
                         exp.addr, exp.hp, exp.tone, exp.strobe, exp.busy, exp.done);
                break;
            end
        end
    endtask

    // Single note followed by the end word: strobe two cycles after play is
    // sampled, tone length from the table, done four cycles past the note.
    task automatic applyStimulus(input vec_t v, input int idx);
        int d, hi, done_k;
        d = int'(v.word[11:8]);
        doReset();
        clearRom();
        rom[0] = v.word;
        loop_en = 1'b0;
        play = 1'b1;
        tick();
        tick();
        tick();
        checkOutput($sformatf("vec%0d strobe", idx), note_strobe, 1);
        checkOutput($sformatf("vec%0d half_period", idx), half_period, v.exp_hp);
        checkOutput($sformatf("vec%0d tone_en", idx), tone_en, v.exp_tone);
        hi = tone_en ? 1 : 0;
        done_k = -1;
        for (int k = 3; k < 200; k++) begin
            tick();
            if (tone_en) hi++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        checkOutput($sformatf("vec%0d tone cycles", idx), hi, v.exp_high);
        checkOutput($sformatf("vec%0d done cycle", idx), done_k, 4 + d * BEAT);
        checkOutput($sformatf("vec%0d busy at done", idx), busy, 0);
        play = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic any;

        vecs[0] = '{w(1, 10, 0), 18'd113636, 1'b1, 8};
        vecs[1] = '{w(2, 1, 1),  18'd95556,  1'b1, 18};
        vecs[2] = '{w(1, 5, 0),  18'd151685, 1'b1, 8};
        vecs[3] = '{w(1, 12, 3), 18'd12654,  1'b1, 8};
        vecs[4] = '{w(3, 7, 2),  18'd33784,  1'b1, 28};
        vecs[5] = '{w(1, 0, 0),  18'd0,      1'b0, 0};
        vecs[6] = '{w(1, 14, 2), 18'd0,      1'b0, 0};
        vecs[7] = '{w(15, 8, 3), 18'd15944,  1'b1, 148};

        clearRom();
        rst = 1'b1;
        play = 1'b0;
        loop_en = 1'b0;
        tick();
        tick();
        checkOutput("reset outputs", {rom_addr, half_period, tone_en, note_strobe, busy, done}, 0);
        rst = 1'b0;
        model_hp = 18'd0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Two-note song with end word, no loop.
        doReset();
        clearRom();
        rom[0] = w(1, 10, 0);
        rom[1] = w(2, 1, 1);
        runTrace("two-note song", 60, 1'b0);

        // Leading rest keeps the held half-period and stays silent.
        doReset();
        clearRom();
        rom[0] = w(1, 0, 0);
        rom[1] = w(1, 5, 0);
        runTrace("rest song", 40, 1'b0);

        doReset();
        runTrace("rest song looping", 150, 1'b1);

        // Full ROM: end of song comes from the address wrap.
        doReset();
        for (int i = 0; i < 8; i++) rom[i] = w(1, 12, 3);
        runTrace("wrap song", 120, 1'b0);
        doReset();
        runTrace("wrap song looping", 120, 1'b1);

        // Stop in the middle of the second note, then restart.
        doReset();
        clearRom();
        rom[0] = w(1, 10, 0);
        rom[1] = w(2, 1, 1);
        play = 1'b1;
        for (int k = 0; k <= 20; k++) tick();
        checkOutput("note2 playing tone", tone_en, 1);
        play = 1'b0;
        tick();
        checkOutput("stop outputs", {rom_addr, tone_en, busy, done}, 0);
        checkOutput("stop holds half_period", half_period, 95556);
        any = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            any = any | done | busy | note_strobe;
        end
        checkOutput("stopped stays idle", any, 0);
        model_hp = 18'd95556;
        runTrace("restart after stop", 40, 1'b0);

        // Reset during the gap of the first note.
        doReset();
        play = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        checkOutput("in gap tone", {tone_en, busy}, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid-gap reset outputs", {rom_addr, half_period, tone_en, note_strobe, busy, done}, 0);
        rst = 1'b0;
        play = 1'b0;
        any = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            any = any | note_strobe | busy | tone_en;
        end
        checkOutput("quiet after reset", any, 0);
        model_hp = 18'd0;
        runTrace("play after reset", 40, 1'b0);

        // Random songs against the timeline model.
        for (int r = 0; r < 6; r++) begin
            doReset();
            for (int i = 0; i < 8; i++)
                rom[i] = {($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3)),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3))};
            runTrace($sformatf("random song %0d", r), 250, 1'($urandom_range(0, 1)));
        end

        doReset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Upstream control stage for the buzzer path. It steps through a melody ROM of packed note words and converts each word into a tone half-period plus enable for the downstream square-wave tone generator that drives `buzzer`. It handles note duration in beats, an articulation gap between notes, rests, end-of-song detection, looping and stop. It contains no audio-rate logic; it only tells the tone generator what to play and when.

## Interface
- `BEAT_CYCLES`, 12_500_000: clk cycles per beat (125 ms at 100 MHz); must be > `GAP_CYCLES`.
- `GAP_CYCLES`, 500_000: silent cycles at the end of every note, counted inside the note's duration.
- `ADDR_W`, 6: ROM address width; song length is at most 2^ADDR_W words.

- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `play`  in  1  level; high = run, low = stop and return to idle.
- `loop_en`  in  1  level; sampled at end of song.
- `rom_addr`  out  ADDR_W  melody ROM address, registered.
- `rom_data`  in  12  ROM word, valid 1 cycle after `rom_addr` changes. Fields: [11:8] duration in beats (0 = end of song); [7:4] note (0 = rest, 1..12 = C..B, 13..15 = rest); [3:2] octave (0 = octave 4 .. 3 = octave 7); [1:0] ignored.
- `half_period`  out  18  tone generator half-period in clk cycles.
- `tone_en`  out  1  tone generator enable (low = silence).
- `note_strobe`  out  1  1-cycle pulse when a new word takes effect.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  1-cycle pulse at a non-looping end of song.

## Operation
- FSM states: IDLE, LOAD, DECODE, PLAY, GAP.
- IDLE: `rom_addr`=0, `tone_en`=0. Goes to LOAD when `play`=1.
- LOAD: waits one cycle for ROM latency, then goes to DECODE.
- DECODE, duration=0 (end of song):
  - `loop_en`=1: `rom_addr`←0, go to LOAD.
  - `loop_en`=0: pulse `done`, go to IDLE.
- DECODE, duration≠0:
  - Register `half_period`.
  - `tone_en` ← 1 if note is 1..12, else 0.
  - Pulse `note_strobe`.
  - Load the counter with dur×BEAT_CYCLES−GAP_CYCLES−1.
  - Go to PLAY.
- PLAY: count down to 0, then `tone_en`←0, load the counter with GAP_CYCLES−1, go to GAP.
- GAP: count down to 0. Then:
  - If `rom_addr` = 2^ADDR_W−1, treat as end of song (same rules as duration=0, without a ROM read).
  - Otherwise `rom_addr`←`rom_addr`+1, go to LOAD.
- Half-period lookup, octave 4 at 100 MHz, round(50e6/f): C 191113, C# 180388, D 170262, D# 160706, E 151685, F 143173, F# 135137, G 127553, G# 120394, A 113636, B♭ 107258, B 101238.
  - Output = table >> octave (logical shift; truncation is acceptable).
  - For rests, `half_period` holds its previous value.
- Counter width: enough for 15×BEAT_CYCLES (28 bits at the defaults).
- `play` low in any state: on the next edge go to IDLE, `tone_en`=0, `rom_addr`=0. No `done` pulse.
- `play` and `loop_en` changes during a note affect only their defined sample points. The exception is `play` falling, which takes effect immediately.

## Timing
- Reset values: `rom_addr`=0, `half_period`=0, `tone_en`=0, `note_strobe`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered; no combinational path from input to output.
- `play` sampled high in IDLE at edge N: `busy`=1 after N. `note_strobe` and `tone_en` rise after edge N+2.
- `tone_en` stays high for exactly dur×BEAT_CYCLES−GAP_CYCLES cycles, then low for GAP_CYCLES cycles.
- The next `note_strobe` comes 2 cycles (LOAD + DECODE) after GAP ends. Note-to-note period = dur×BEAT_CYCLES+2.
- Loop restart costs 2 extra cycles: the DECODE of the end word, then LOAD.
- `done` and the return to IDLE happen on the same edge.
- Reset asserted mid-note: all outputs take their reset values on that edge.

## Test plan
- Use BEAT_CYCLES=10, GAP_CYCLES=2, ADDR_W=3 throughout.
- ROM {dur1 A oct0, dur2 C oct1, dur0}, `loop_en`=0, `play` raised:
  - First strobe 3 cycles after `play`, `half_period`=113636, `tone_en` high 8 cycles, low 2.
  - Second strobe 2 cycles later, `half_period`=95556, `tone_en` high 18 cycles.
  - `done` 1 cycle pulse, `busy`→0.
- ROM {dur1 rest, dur1 E oct0, dur0}: first note `tone_en`=0 throughout with `half_period` unchanged; then 151685.
- Same ROM with `loop_en`=1: after the end word, `rom_addr` returns to 0 and the strobe repeats indefinitely with no `done`.
- ROM of 8 words, all dur1 B oct3: after word 7, end of song at wrap. `done` pulses and `rom_addr` never exceeds 7.
- Drop `play` mid-PLAY of note 2: next edge gives `tone_en`=0, `busy`=0, `rom_addr`=0, no `done`. Re-raise `play`: restarts at word 0.
- Assert `rst` for 1 cycle mid-GAP: all outputs are at reset values the next cycle, and no strobe follows until `play` is seen in IDLE.
